grid_scanner: RTL and testbench
===============================

Name: grid_scanner

Overview:
- Reads the 8x8 life grid produced by the cell matrix and serialises it, one row per beat, onto a valid/ready row stream for display drivers and host readout.
- On a start pulse it snapshots the whole grid, so the grid may keep evolving while the snapshot is streamed row 0 through row 7.
- It also produces a per-frame population count.

Parameters:
- ROWS, 8, rows per frame; row index width is clog2(ROWS).
- COLS, 8, cells per row; sets the row_data width.
- IDLE_GAP, 0, mandatory idle cycles after frame_done before a new start is accepted.

Ports:
- clk  in  1  system clock, rising edge.
- _rst  in  1  asynchronous active-low reset.
- grid  in  [0:ROWS-1][0:COLS-1]  live grid from the cell matrix; grid[r][c] = 1 means the cell is alive.
- start  in  1  request a frame scan; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until the end of the frame_done cycle and the following gap.
- row_data  out  COLS  snapshot row; row_data[COLS-1] = grid[r][0], row_data[0] = grid[r][COLS-1].
- row_idx  out  clog2(ROWS)  index of the row currently presented.
- row_valid  out  1  row_data and row_idx are valid.
- row_ready  in  1  sink accepts the row.
- frame_last  out  1  high with row_valid while row_idx == ROWS-1.
- frame_done  out  1  single-cycle pulse after the last row transfers.
- pop_count  out  7  live cells in the last completed frame, range 0..64.

Behaviour:
- Reset (_rst low, asynchronous):
  - State goes to IDLE; the snapshot register is cleared.
  - All outputs are 0: busy, row_valid, row_idx, row_data, frame_last, frame_done, pop_count.
  - Reset mid-frame discards the frame; no frame_done is issued.
- FSM states: IDLE, SEND, DONE, GAP.
- IDLE:
  - start high at rising edge N: capture grid into the snapshot, set row_idx = 0 and the accumulator to 0, go to SEND.
  - row_valid is high in cycle N+1, so latency from start to the first row is 1 cycle.
- SEND:
  - row_valid = 1; row_data = snapshot[row_idx].
  - A transfer occurs on any edge where row_valid && row_ready.
  - While row_ready is low, row_data, row_idx and frame_last hold stable; row_valid never drops until the row transfers.
  - On each transfer the accumulator adds popcount(row_data), 4 bits zero-extended to 7.
  - Transfer with row_idx < ROWS-1: increment row_idx, so rows are back-to-back when row_ready stays high.
  - Transfer with row_idx == ROWS-1: go to DONE; row_idx wraps to 0.
- DONE (one cycle):
  - row_valid = 0, frame_done = 1.
  - pop_count takes the accumulator value and holds it until the next frame_done or reset.
  - Next state is GAP if IDLE_GAP > 0, otherwise IDLE.
- GAP: count IDLE_GAP cycles, then go to IDLE.
- start outside IDLE is ignored and is not queued; start held high in IDLE begins the next frame immediately.
- Grid changes during SEND do not affect the frame being streamed.
- Minimum frame time with row_ready constantly high: ROWS + 1 + IDLE_GAP cycles after the start edge.

Optional Feature:
- Macro SCAN_HOLD_EN.
- Defined:
  - Adds input hold (1 bit).
  - While hold is high in IDLE, start is ignored.
  - While hold is high in SEND, row_valid is forced low and no transfer occurs.
  - Row position, snapshot and accumulator are preserved; streaming resumes with the same row once hold drops.
- Undefined: no hold port; behaviour exactly as above.

Decomposition:
- Shared package life_pkg:
  - GRID_ROWS = 8, GRID_COLS = 8.
  - typedef row_t = logic [GRID_COLS-1:0].
  - typedef grid_t = logic [0:GRID_ROWS-1][0:GRID_COLS-1].
  - Enum scan_state_t {IDLE, SEND, DONE, GAP}.
- One sub-module, row_popcount: purely combinational, row_t in, 4-bit count out; shared with future statistics blocks.

Test Plan:
- Checkerboard grid (grid[r][c] = (r+c) odd), start pulse, row_ready = 1 -> rows 0..7 = 8'h55, 8'hAA alternating in consecutive cycles. frame_last only on row_idx 7. frame_done one cycle later. pop_count = 32.
- Blinker snapshot (row 4 = 8'h38), then grid changed the cycle after start -> streamed data still shows only row 4 = 8'h38; pop_count = 3.
- row_ready toggled 1,0,0,1 pseudo-randomly -> row_data and row_idx stable while stalled, no duplicated or skipped rows, exactly 8 transfers.
- start pulsed during SEND and DONE -> ignored; a single frame_done. With IDLE_GAP = 3, start immediately after DONE is ignored until 3 cycles have elapsed.
- _rst asserted asynchronously mid-clock after row 3 transfers -> all outputs 0 immediately, no frame_done. Next start streams from row_idx 0 and pop_count counts only the new frame.
- All-ones grid -> pop_count = 64, with no overflow of the 7-bit field.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types for the life grid and its scan/readout blocks.
package life_pkg;

   localparam int GRID_ROWS = 8;
   localparam int GRID_COLS = 8;

   typedef logic [GRID_COLS-1:0] row_t;
   typedef logic [0:GRID_ROWS-1][0:GRID_COLS-1] grid_t;

   typedef enum logic [1:0] {IDLE, SEND, DONE, GAP} scan_state_t;

endpackage

// File: rtl/row_popcount.sv
// Combinational live-cell count for one grid row.
module row_popcount
   import life_pkg::*;
(
   input  row_t       row,
   output logic [3:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < GRID_COLS; i++) begin
         count = count + {3'b000, row[i]};
      end
   end

endmodule

// File: rtl/grid_scanner.sv
// Snapshots the life grid on start and streams it one row per valid/ready beat,
// reporting the frame's population. Optional `SCAN_HOLD_EN adds a hold input.
module grid_scanner
   import life_pkg::*;
#(
   parameter int ROWS     = GRID_ROWS,
   parameter int COLS     = GRID_COLS,
   parameter int IDLE_GAP = 0
) (
   input  logic                                clk,
   input  logic                                _rst,
   input  logic [0:ROWS-1][0:COLS-1]           grid,
   input  logic                                start,
`ifdef SCAN_HOLD_EN
   input  logic                                hold,
`endif
   output logic                                busy,
   output logic [COLS-1:0]                     row_data,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_idx,
   output logic                                row_valid,
   input  logic                                row_ready,
   output logic                                frame_last,
   output logic                                frame_done,
   output logic [6:0]                          pop_count
);

   localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
   localparam logic [IW-1:0] LAST = IW'(ROWS - 1);

   scan_state_t                state;
   logic [0:ROWS-1][0:COLS-1]  snap;
   logic [IW-1:0]              idx;
   logic [IW-1:0]              next_idx;
   logic [COLS-1:0]            data;
   logic [6:0]                 acc;
   logic [6:0]                 acc_next;
   logic [6:0]                 pop;
   logic [GW-1:0]              gap_cnt;
   logic [3:0]                 row_cnt;
   logic                       valid;
   logic                       accept;
   logic                       transfer;

`ifdef SCAN_HOLD_EN
   assign accept = start && !hold;
   assign valid  = (state == SEND) && !hold;
`else
   assign accept = start;
   assign valid  = (state == SEND);
`endif

   assign transfer = valid && row_ready;
   assign next_idx = idx + 1'b1;
   assign acc_next = acc + {3'b000, row_cnt};

   row_popcount u_row_popcount (
      .row   (data),
      .count (row_cnt)
   );

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state   <= IDLE;
         snap    <= '0;
         idx     <= '0;
         data    <= '0;
         acc     <= '0;
         pop     <= '0;
         gap_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  snap  <= grid;
                  data  <= grid[0];
                  idx   <= '0;
                  acc   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (transfer) begin
                  acc <= acc_next;
                  if (idx == LAST) begin
                     // pop_count is already final while frame_done is high
                     idx   <= '0;
                     pop   <= acc_next;
                     state <= DONE;
                  end else begin
                     idx  <= next_idx;
                     data <= snap[next_idx];
                  end
               end
            end
            DONE: begin
               if (IDLE_GAP > 0) begin
                  gap_cnt <= GW'(IDLE_GAP - 1);
                  state   <= GAP;
               end else begin
                  state <= IDLE;
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy       = (state != IDLE);
   assign row_valid  = valid;
   assign row_idx    = idx;
   assign row_data   = data;
   assign frame_last = valid && (idx == LAST);
   assign frame_done = (state == DONE);
   assign pop_count  = pop;

endmodule

// File: tb/tb_grid_scanner.sv
// Scoreboard bench for grid_scanner built with IDLE_GAP = 3.
module tb_grid_scanner;

   typedef logic [0:7][0:7] tgrid_t;
   typedef struct packed {
      logic [2:0] idx;
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic       clk = 1'b0;
   logic       _rst;
   tgrid_t     grid;
   logic       start;
   logic       busy;
   logic [7:0] row_data;
   logic [2:0] row_idx;
   logic       row_valid;
   logic       row_ready;
   logic       frame_last;
   logic       frame_done;
   logic [6:0] pop_count;

   grid_scanner #(.ROWS(8), .COLS(8), .IDLE_GAP(3)) dut (
      .clk        (clk),
      ._rst       (_rst),
      .grid       (grid),
      .start      (start),
      .busy       (busy),
      .row_data   (row_data),
      .row_idx    (row_idx),
      .row_valid  (row_valid),
      .row_ready  (row_ready),
      .frame_last (frame_last),
      .frame_done (frame_done),
      .pop_count  (pop_count)
   );

   always #5 clk = ~clk;

   beat_t exp_q[$];
   beat_t obs_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   int         n_xfer, n_done, first_v, done_cyc, unstable;
   logic [6:0] pop_at_done;
   logic       busy_at_done;

   function automatic logic [7:0] row_of(input tgrid_t g, input int r);
      logic [7:0] d;
      for (int c = 0; c < 8; c++) d[7-c] = g[r][c];
      return d;
   endfunction

   function automatic int pop_of(input tgrid_t g);
      int n = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            n += int'(g[r][c]);
      return n;
   endfunction

   task automatic push_frame(input tgrid_t g);
      beat_t b;
      for (int r = 0; r < 8; r++) begin
         b.idx  = 3'(r);
         b.data = row_of(g, r);
         b.last = (r == 7);
         exp_q.push_back(b);
      end
   endtask

   // Drives row_ready and records every transfer until frame_done (or stop_after beats).
   task automatic collect(input bit stall, input int start_cyc, input bit start_at_done,
                          input int stop_after, input bit chg, input tgrid_t ng);
      logic [7:0] pd;
      logic [2:0] pi;
      bit         ps;
      bit         r;
      beat_t      b;
      n_xfer = 0; n_done = 0; first_v = 0; done_cyc = 0; unstable = 0;
      ps = 1'b0; pd = '0; pi = '0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         start = (k == start_cyc);
         if (k == 1 && chg) grid = ng;
         if (ps && (!row_valid || row_data !== pd || row_idx !== pi)) unstable++;
         if (row_valid && first_v == 0) first_v = k;
         if (frame_done) begin
            n_done++;
            done_cyc     = k;
            pop_at_done  = pop_count;
            busy_at_done = busy;
            start        = start_at_done;
            break;
         end
         r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         row_ready = r;
         if (row_valid && r) begin
            b.idx = row_idx; b.data = row_data; b.last = frame_last;
            obs_q.push_back(b);
            n_xfer++;
            if (stop_after > 0 && n_xfer == stop_after) break;
         end
         ps = row_valid && !r;
         pd = row_data;
         pi = row_idx;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      start = 1'b0;
      row_ready = 1'b1;
      repeat (6) @(negedge clk);
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      _rst = 1'b1; start = 1'b0; row_ready = 1'b1; grid = '0;
      #2 _rst = 1'b0;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (row_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", row_valid); end
      n_vec++; if ({row_idx, row_data, frame_last, frame_done, pop_count} !== '0) begin
         n_err++; $display("FAIL reset_outputs idx=%0d data=%h last=%b done=%b pop=%0d want all 0",
                           row_idx, row_data, frame_last, frame_done, pop_count);
      end
      repeat (2) @(negedge clk);
      _rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_checkerboard();
      beat_t e, o;
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) grid[r][c] = ((r + c) % 2 == 1);
      push_frame(grid);
      @(negedge clk); start = 1'b1;
      collect(1'b0, 0, 1'b0, 0, 1'b0, '0);
      n_vec++; if (first_v !== 1) begin n_err++; $display("FAIL cb_latency got %0d want 1", first_v); end
      n_vec++; if (done_cyc !== 9) begin n_err++; $display("FAIL cb_done_cycle got %0d want 9", done_cyc); end
      n_vec++; if (pop_at_done !== 7'd32) begin n_err++; $display("FAIL cb_pop got %0d want 32", pop_at_done); end
      n_vec++; if (busy_at_done !== 1'b1) begin n_err++; $display("FAIL cb_busy_done got %b want 1", busy_at_done); end
      n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL cb_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_err++; $display("FAIL cb_row got %h want %h", o, e); end
      end
      settle();
   endtask

   task automatic test_snapshot();
      beat_t  e, o;
      tgrid_t ng;
      grid = '0;
      for (int c = 2; c <= 4; c++) grid[4][c] = 1'b1;
      ng = '0;
      for (int r = 3; r <= 5; r++) ng[r][3] = 1'b1;
      push_frame(grid);
      @(negedge clk); start = 1'b1;
      collect(1'b0, 0, 1'b0, 0, 1'b1, ng);
      n_vec++; if (pop_at_done !== 7'd3) begin n_err++; $display("FAIL snap_pop got %0d want 3", pop_at_done); end
      n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL snap_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_err++; $display("FAIL snap_row got %h want %h", o, e); end
      end
      settle();
   endtask

   task automatic test_backpressure();
      beat_t e, o;
      for (int r = 0; r < 8; r++) grid[r] = 8'($urandom);
      push_frame(grid);
      @(negedge clk); start = 1'b1;
      collect(1'b1, 0, 1'b0, 0, 1'b0, '0);
      n_vec++; if (n_xfer !== 8) begin n_err++; $display("FAIL bp_transfers got %0d want 8", n_xfer); end
      n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
      n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL bp_done got %0d want 1", n_done); end
      n_vec++; if (pop_at_done !== 7'(pop_of(grid))) begin n_err++; $display("FAIL bp_pop got %0d want %0d", pop_at_done, pop_of(grid)); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_err++; $display("FAIL bp_row got %h want %h", o, e); end
      end
      settle();
   endtask

   task automatic test_start_ignored();
      beat_t e, o;
      int    extra_valid, extra_done;
      for (int r = 0; r < 8; r++) grid[r] = 8'($urandom);
      push_frame(grid);
      @(negedge clk); start = 1'b1;
      collect(1'b0, 3, 1'b1, 0, 1'b0, '0);
      extra_valid = 0; extra_done = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         start = 1'b0;
         if (row_valid) extra_valid++;
         if (frame_done) extra_done++;
      end
      n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL ign_done got %0d want 1", n_done); end
      n_vec++; if (extra_valid !== 0 || extra_done !== 0) begin
         n_err++; $display("FAIL ign_queued valid=%0d done=%0d want 0 0", extra_valid, extra_done);
      end
      n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ign_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_err++; $display("FAIL ign_row got %h want %h", o, e); end
      end
      settle();
   endtask

   task automatic test_gap();
      beat_t e, o;
      int    idle_at, valid_at;
      for (int r = 0; r < 8; r++) grid[r] = 8'($urandom);
      push_frame(grid);
      push_frame(grid);
      @(negedge clk); start = 1'b1;
      collect(1'b0, 0, 1'b1, 0, 1'b0, '0);
      idle_at = 0; valid_at = 0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (!busy && idle_at == 0) idle_at = j;
         if (row_valid) begin
            valid_at = j; start = 1'b0; row_ready = 1'b0;
            break;
         end
      end
      start = 1'b0;
      n_vec++; if (idle_at !== 4) begin n_err++; $display("FAIL gap_idle got %0d want 4", idle_at); end
      n_vec++; if (valid_at !== 5) begin n_err++; $display("FAIL gap_restart got %0d want 5", valid_at); end
      collect(1'b0, 0, 1'b0, 0, 1'b0, '0);
      n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL gap_second_done got %0d want 1", n_done); end
      n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL gap_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_err++; $display("FAIL gap_row got %h want %h", o, e); end
      end
      settle();
   endtask

   task automatic test_all_ones();
      beat_t e, o;
      grid = '1;
      push_frame(grid);
      @(negedge clk); start = 1'b1;
      collect(1'b0, 0, 1'b0, 0, 1'b0, '0);
      n_vec++; if (pop_at_done !== 7'd64) begin n_err++; $display("FAIL ones_pop got %0d want 64", pop_at_done); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_err++; $display("FAIL ones_row got %h want %h", o, e); end
      end
      settle();
   endtask

   task automatic test_async_reset();
      beat_t e, o;
      int    dones;
      grid = '1;
      @(negedge clk); start = 1'b1;
      collect(1'b0, 0, 1'b0, 4, 1'b0, '0);
      @(posedge clk);
      #3 _rst = 1'b0;
      #1;
      n_vec++; if ({busy, row_valid, row_idx, row_data, frame_last, frame_done, pop_count} !== '0) begin
         n_err++; $display("FAIL arst_outputs busy=%b valid=%b idx=%0d data=%h last=%b done=%b pop=%0d want all 0",
                           busy, row_valid, row_idx, row_data, frame_last, frame_done, pop_count);
      end
      @(negedge clk); _rst = 1'b1;
      dones = 0;
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         if (frame_done || busy) dones++;
      end
      n_vec++; if (dones !== 0) begin n_err++; $display("FAIL arst_no_done got %0d active cycles want 0", dones); end
      exp_q.delete(); obs_q.delete();
      for (int r = 0; r < 8; r++) grid[r] = 8'h81;
      push_frame(grid);
      @(negedge clk); start = 1'b1;
      collect(1'b0, 0, 1'b0, 0, 1'b0, '0);
      n_vec++; if (pop_at_done !== 7'd16) begin n_err++; $display("FAIL arst_pop got %0d want 16", pop_at_done); end
      n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL arst_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_err++; $display("FAIL arst_row got %h want %h", o, e); end
      end
      settle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_checkerboard();
      test_snapshot();
      test_backpressure();
      test_start_ignored();
      test_gap();
      test_all_ones();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
